// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: encrypt handshake and stage enable/done bundle for aes_round_ctrl.
// master = controller side (drives enables, ark_sel, round_idx, busy, done[, error]),
// slave  = surrounding datapath/top (drives start and the four stage done inputs).
// error exists only when AES_CTRL_TIMEOUT_EN is defined.
interface aes_round_ctrl_if;
  logic start, sb_done, sr_done, mc_done, ark_done;
  logic sb_en, sr_en, mc_en, ark_en, busy, done;
  logic [1:0] ark_sel;
  logic [3:0] round_idx;
`ifdef AES_CTRL_TIMEOUT_EN
  logic error;
  modport master(input start, sb_done, sr_done, mc_done, ark_done,
                 output sb_en, sr_en, mc_en, ark_en, ark_sel, round_idx, busy, done, error);
  modport slave(output start, sb_done, sr_done, mc_done, ark_done,
                input sb_en, sr_en, mc_en, ark_en, ark_sel, round_idx, busy, done, error);
`else
  modport master(input start, sb_done, sr_done, mc_done, ark_done,
                 output sb_en, sr_en, mc_en, ark_en, ark_sel, round_idx, busy, done);
  modport slave(output start, sb_done, sr_done, mc_done, ark_done,
                input sb_en, sr_en, mc_en, ark_en, ark_sel, round_idx, busy, done);
`endif
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128/192/256 round sequencer driving SubBytes/ShiftRows/MixColumns/AddRoundKey.
// Ports: clk, reset (sync, active-high), bus (aes_round_ctrl_if.master):
//   start in, {sb,sr,mc,ark}_done in, {sb,sr,mc,ark}_en out, ark_sel[1:0] out,
//   round_idx[3:0] out, busy out, done out, error out (only with AES_CTRL_TIMEOUT_EN).
// Optional feature macro: AES_CTRL_TIMEOUT_EN adds a per-state watchdog of TIMEOUT_CYCLES.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic clk,
  input logic reset,
  aes_round_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, FINISH} state_t;
  state_t state, state_nx;
  logic first, stage_done, last;
  logic [3:0] round_idx;
  logic [1:0] ark_sel;
  if (NR < 2 || NR > 14 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aes_round_ctrl: illegal NR or TIMEOUT_CYCLES");
  end
  assign last = round_idx == 4'(NR);
  // stage modules may hold done high while enabled, so the first cycle of a state ignores it
  always_comb stage_done = ~first & ((state == INIT_ARK || state == ARK) ? bus.ark_done :
                                     state == SUB   ? bus.sb_done :
                                     state == SHIFT ? bus.sr_done :
                                     state == MIX   ? bus.mc_done : 1'b0);
`ifdef AES_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic timeout;
  assign timeout = state != IDLE && state != FINISH && !stage_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      bus.error <= 1'b0;
    end else begin
      cnt <= state_nx != state ? '0 : cnt + 1'b1;
      bus.error <= timeout;
    end
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = bus.start ? INIT_ARK : IDLE;
      INIT_ARK: state_nx = stage_done ? SUB : state;
      SUB:      state_nx = stage_done ? SHIFT : state;
      SHIFT:    state_nx = stage_done ? (last ? ARK : MIX) : state;
      MIX:      state_nx = stage_done ? ARK : state;
      ARK:      state_nx = stage_done ? (last ? FINISH : SUB) : state;
      default:  state_nx = IDLE;
    endcase
`ifdef AES_CTRL_TIMEOUT_EN
    if (timeout) state_nx = IDLE;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      first <= 1'b0;
      round_idx <= '0;
      ark_sel <= '0;
    end else begin
      first <= state_nx != state;
      round_idx <= state_nx == IDLE ? 4'd0 :
                   (state_nx == SUB && state != SUB) ? round_idx + 4'd1 : round_idx;
      ark_sel <= (state_nx == ARK && state != ARK) ? (last ? 2'd2 : 2'd1) :
                 (state_nx == INIT_ARK && state != INIT_ARK) ? 2'd0 : ark_sel;
    end
  always_comb begin
    bus.sb_en = state == SUB;
    bus.sr_en = state == SHIFT;
    bus.mc_en = state == MIX;
    bus.ark_en = state == INIT_ARK || state == ARK;
    bus.busy = state != IDLE;
    bus.done = state == FINISH;
    bus.ark_sel = ark_sel;
    bus.round_idx = round_idx;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl (NR = 10) with latency-programmable stage models.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  logic clk = 0, reset = 1, hold_hi = 0;
  always #5 clk = ~clk;
  aes_round_ctrl_if bus();
  aes_round_ctrl #(.NR(NR), .TIMEOUT_CYCLES(15)) dut(.clk(clk), .reset(reset), .bus(bus));
  // stage models: done rises once the enable has been high for lat_tab[stage][round] cycles
  int lat_tab[4][16];
  int cnt[4];
  logic [3:0] en, dn;
  assign en = {bus.ark_en, bus.mc_en, bus.sr_en, bus.sb_en};
  always_ff @(posedge clk)
    for (int s = 0; s < 4; s++) cnt[s] <= en[s] ? cnt[s] + 1 : 0;
  always_comb
    for (int s = 0; s < 4; s++) dn[s] = hold_hi | (en[s] && cnt[s] >= lat_tab[s][bus.round_idx]);
  assign bus.sb_done = dn[0];
  assign bus.sr_done = dn[1];
  assign bus.mc_done = dn[2];
  assign bus.ark_done = dn[3];
  typedef struct packed {
    logic sb, sr, mc, ark;
    logic [1:0] sel;
    logic [3:0] rnd;
    logic busy, done;
  } obs_t;
  typedef struct {
    bit hold;
    int st;
    int rnd;
    int extra;
    bit repulse;
    int exp_done;
  } vec_t;
  obs_t exp_q[$];
  int tests = 0, fails = 0;
  function automatic obs_t sample();
    obs_t o;
    o = '{bus.sb_en, bus.sr_en, bus.mc_en, bus.ark_en, bus.ark_sel, bus.round_idx, bus.busy, bus.done};
    return o;
  endfunction
  task automatic check(input string nm, input int cyc, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got sb/sr/mc/ark=%b%b%b%b sel=%0d rnd=%0d busy=%b done=%b, expected %b%b%b%b sel=%0d rnd=%0d busy=%b done=%b",
               nm, cyc, act.sb, act.sr, act.mc, act.ark, act.sel, act.rnd, act.busy, act.done,
               exp.sb, exp.sr, exp.mc, exp.ark, exp.sel, exp.rnd, exp.busy, exp.done);
    end
  endtask
  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // reference schedule: each stage occupies (latency + 1) cycles, or 2 when done is stuck high
  task automatic add_stage(input int s, input int r, input logic [1:0] sel);
    obs_t o;
    int n;
    o = '0;
    o.sb = s == 0;
    o.sr = s == 1;
    o.mc = s == 2;
    o.ark = s == 3;
    o.sel = sel;
    o.rnd = 4'(r);
    o.busy = 1'b1;
    n = hold_hi ? 2 : lat_tab[s][r] + 1;
    repeat (n) exp_q.push_back(o);
  endtask
  task automatic build_expected();
    obs_t o;
    logic [1:0] sel;
    exp_q = {};
    sel = 2'd0;
    add_stage(3, 0, sel);
    for (int r = 1; r <= NR; r++) begin
      add_stage(0, r, sel);
      add_stage(1, r, sel);
      if (r < NR) add_stage(2, r, sel);
      sel = r < NR ? 2'd1 : 2'd2;
      add_stage(3, r, sel);
    end
    o = '0;
    o.sel = sel;
    o.rnd = 4'(NR);
    o.busy = 1'b1;
    o.done = 1'b1;
    exp_q.push_back(o);
    o.rnd = 4'd0;
    o.busy = 1'b0;
    o.done = 1'b0;
    exp_q.push_back(o);
  endtask
  task automatic set_lats(input int st, input int rnd, input int extra);
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 16; r++) lat_tab[s][r] = 1;
    lat_tab[st][rnd] += extra;
  endtask
  // called at a negedge with the DUT idle; start is sampled at the next edge (cycle 0)
  task automatic run_check(input string nm, input bit repulse, output int dc, output int np);
    obs_t a;
    build_expected();
    dc = -1;
    np = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      a = sample();
      if (a.done) begin
        np++;
        if (dc < 0) dc = i + 1;
      end
      check(nm, i + 1, a, exp_q[i]);
      bus.start = repulse && (i + 1 == 5 || i + 1 == 40);
      @(negedge clk);
    end
    bus.start = 0;
  endtask
  vec_t vt[7];
  int dc, np;
  bit found;
  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 81};
    vt[1] = '{0, 0, 0, 0, 1, 81};
    vt[2] = '{0, 1, 4, 3, 0, 84};
    vt[3] = '{1, 0, 0, 0, 0, 81};
    vt[4] = '{0, 0, 10, 2, 0, 83};
    vt[5] = '{0, 3, 0, 5, 0, 86};
    vt[6] = '{0, 2, 9, 1, 0, 82};
    set_lats(0, 0, 0);
    bus.start = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset_state", 0, sample(), '0);
    for (int v = 0; v < 7; v++) begin
      hold_hi = vt[v].hold;
      set_lats(vt[v].st, vt[v].rnd, vt[v].extra);
      run_check($sformatf("vec%0d_trace", v), vt[v].repulse, dc, np);
      check_int($sformatf("vec%0d_done_cycle", v), dc, vt[v].exp_done);
      check_int($sformatf("vec%0d_done_pulses", v), np, 1);
    end
    hold_hi = 0;
    set_lats(0, 0, 0);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++)
      if (bus.mc_en && bus.round_idx == 4'd5) found = 1;
      else @(negedge clk);
    check_int("reach_mix_round5", int'(found), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      check("reset_abort", k, sample(), '0);
      @(negedge clk);
    end
    run_check("after_reset_trace", 0, dc, np);
    check_int("after_reset_done_cycle", dc, 81);
    for (int it = 0; it < 20; it++) begin
      for (int s = 0; s < 4; s++)
        for (int r = 0; r < 16; r++) lat_tab[s][r] = int'($urandom_range(1, 4));
      run_check($sformatf("rand%0d_trace", it), bit'($urandom_range(0, 1)), dc, np);
      check_int($sformatf("rand%0d_done_pulses", it), np, 1);
    end
`ifdef AES_CTRL_TIMEOUT_EN
    begin
      int ec, ecnt, dcnt;
      set_lats(0, 1, 1000);
      ec = -1;
      ecnt = 0;
      dcnt = 0;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      for (int i = 1; i <= 30; i++) begin
        if (bus.error) begin
          ecnt++;
          if (ec < 0) begin
            ec = i;
            check("timeout_abort_state", i, sample(), '0);
          end
        end
        if (bus.done) dcnt++;
        @(negedge clk);
      end
      check_int("timeout_error_cycle", ec, 18);
      check_int("timeout_error_pulses", ecnt, 1);
      check_int("timeout_no_done", dcnt, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Round sequencer for the AES-128/192/256 encryption datapath.
- Drives the enable inputs of the SubBytes, ShiftRows, MixColumns and AddRoundKey stage modules and waits for each stage's done handshake.
- Counts rounds, skips MixColumns in the final round, and issues round-key index and AddRoundKey source-select to the datapath muxes.
- Sits between the top-level encrypt interface (start/done) and the stage modules.

Parameters:
- NR, 10, number of AES rounds (10/12/14 for 128/192/256-bit keys); legal range 2..14.
- TIMEOUT_CYCLES, 15, per-stage watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one block encryption; sampled only in IDLE.
- sb_done  input  1  SubBytes stage done.
- sr_done  input  1  ShiftRows stage done.
- mc_done  input  1  MixColumns stage done.
- ark_done  input  1  AddRoundKey stage done.
- sb_en  output  1  SubBytes enable.
- sr_en  output  1  ShiftRows enable.
- mc_en  output  1  MixColumns enable.
- ark_en  output  1  AddRoundKey enable.
- ark_sel  output  2  AddRoundKey data source: 0 = plaintext, 1 = MixColumns out, 2 = ShiftRows out; 3 is never driven.
- round_idx  output  4  current round, 0..NR; also the round-key index.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; ciphertext valid at the AddRoundKey output.
- error  output  1  watchdog pulse; present only with AES_CTRL_TIMEOUT_EN.

Behaviour:
- Reset:
  - state = IDLE.
  - All enables = 0, ark_sel = 0, round_idx = 0, busy = 0, done = 0, error = 0.
  - Reset mid-operation aborts immediately: all outputs take their reset values in the cycle after the reset edge, and no done pulse is produced.
- States: IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, FINISH.
- IDLE:
  - start = 1 -> INIT_ARK with round_idx = 0.
  - start in any other state is ignored and is not queued.
- Stage states (INIT_ARK, SUB, SHIFT, MIX, ARK):
  - The matching enable is held high for the whole state; all other enables are low.
  - The state uses a first-cycle flag, and the matching done input is ignored in the first cycle of the state. This masks stale done levels that stage modules hold while enabled.
  - From the second cycle on, done sampled high ends the state at that edge.
  - While done stays low, the state and its enable are held.
- Transitions:
  - INIT_ARK -> SUB, with round_idx = 1 on entry to SUB.
  - SUB -> SHIFT.
  - SHIFT -> MIX if round_idx < NR; SHIFT -> ARK if round_idx == NR.
  - MIX -> ARK.
  - ARK -> SUB with round_idx + 1 if round_idx < NR; ARK -> FINISH if round_idx == NR.
  - FINISH -> IDLE after one cycle.
- ark_sel:
  - 0 in INIT_ARK.
  - 1 in ARK for rounds 1..NR-1.
  - 2 in ARK for round NR.
  - Holds its last value outside ARK states.
- round_idx holds its value in FINISH and returns to 0 in IDLE.
- FINISH: done = 1 and busy = 1 for that single cycle.
- Latency with 1-cycle stage modules: every stage takes exactly 2 cycles, so done is high in cycle 8*NR+1 after the start edge (cycle 81 for NR = 10).
- mc_en is never asserted in round NR.

Optional Feature:
- Macro: AES_CTRL_TIMEOUT_EN.
- When defined:
  - A per-state cycle counter is cleared on every state entry.
  - If done has not been accepted when the counter reaches TIMEOUT_CYCLES, the block asserts error for one cycle and returns to IDLE.
  - The abort clears all enables and sets round_idx = 0; done is not pulsed.
- When undefined:
  - The error port and the counter are absent.
  - Stage states wait indefinitely for their done input.

Test Plan:
- Nominal run, NR = 10, 1-cycle stage models, start pulse at cycle 0:
  - Enable order is ark, then (sb, sr, mc, ark) for rounds 1-9, then sb, sr, ark for round 10.
  - Each enable is high for 2 cycles; done is high only in cycle 81.
  - ark_sel sequence is 0, 1 (x9), 2; round_idx steps 0..10.
- start re-pulsed at cycles 5 and 40 during a run -> no effect; a single done at cycle 81; busy stays continuously high for cycles 1-81.
- reset asserted for 1 cycle while round_idx = 5 (in MIX) -> next cycle all enables 0, busy 0, round_idx 0. A new start then completes in 81 cycles.
- sr_done delayed by 3 extra cycles in round 4 only -> sr_en held for 5 cycles; done at cycle 84.
- Stage models hold done permanently high -> every stage state still lasts exactly 2 cycles; done at cycle 81.
- With AES_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES = 15, sb_done stuck at 0 in round 1 -> error pulse 15 cycles after SUB entry, then IDLE with sb_en = 0 and no done pulse.
